task_sequencer: RTL and testbench

- Sequential front-end for the lab datapath controller. Steps through a small stored program of task codes and drives the controller's 4-bit task_select, one step at a time.
- Each step is held for a programmed number of cycles (dwell). A one-cycle register-write strobe fires at the end of each step.
- Uses a start/busy/done handshake toward the testbench or top level, plus an abort input.

---
 rtl/task_seq_pkg.sv | 28 ++
 rtl/task_seq_mem.sv | 29 ++
 rtl/task_sequencer.sv | 146 ++++++++++++++
 tb/tb_task_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/task_seq_pkg.sv
// Shared types and constants for the task sequencer.
// The optional looping feature is enabled with the TASK_SEQ_LOOP_EN macro.
package task_seq_pkg;

  localparam int TASK_W  = 4;
  localparam int DWELL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [TASK_W-1:0] TASK_LOAD_CONST = 4'd0;
  localparam logic [TASK_W-1:0] TASK_ADD        = 4'd1;
  localparam logic [TASK_W-1:0] TASK_SHIFT_ALU  = 4'd2;
  localparam logic [TASK_W-1:0] TASK_HOLD_A     = 4'd3;
  localparam logic [TASK_W-1:0] TASK_HOLD_B     = 4'd4;
  localparam logic [TASK_W-1:0] TASK_ROTATE     = 4'd5;
  localparam logic [TASK_W-1:0] TASK_SHIFT_B    = 4'd6;
  localparam logic [TASK_W-1:0] TASK_REPEAT     = 4'd7;

  typedef struct packed {
    logic [TASK_W-1:0]  task_code;
    logic [DWELL_W-1:0] dwell;
  } entry_t;

endpackage

// File: rtl/task_seq_mem.sv
// Program register file: one synchronous write port, one combinational read
// port, cleared by the asynchronous reset.
module task_seq_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 7,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/task_sequencer.sv
// Steps through a stored program of task codes, holding each for dwell+1 cycles.
// Define TASK_SEQ_LOOP_EN to add loop_mode/wrap for continuous looping.
module task_sequencer
  import task_seq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TASK_W  = 4,
  parameter int DWELL_W = 3,
  parameter logic [TASK_W-1:0] IDLE_TASK = '0,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int LEN_W  = IDX_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [IDX_W-1:0]   prog_addr,
  input  logic [TASK_W-1:0]  prog_task,
  input  logic [DWELL_W-1:0] prog_dwell,
  input  logic [LEN_W-1:0]   prog_len,
  input  logic               start,
  input  logic               abort,
`ifdef TASK_SEQ_LOOP_EN
  input  logic               loop_mode,
  output logic               wrap,
`endif
  output logic               busy,
  output logic               done,
  output logic [TASK_W-1:0]  task_select,
  output logic [IDX_W-1:0]   step_idx,
  output logic               step_valid
);

  localparam int ENTRY_W = TASK_W + DWELL_W;

  state_t               state;
  logic [DWELL_W-1:0]   cnt;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     len_capped;
  logic [ENTRY_W-1:0]   rd_entry;
  logic [TASK_W-1:0]    rd_task;
  logic [DWELL_W-1:0]   rd_dwell;
  logic [IDX_W-1:0]     rd_addr;
  logic                 last_step;
  logic                 mem_we;

  assign len_capped = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
  assign last_step  = ({1'b0, step_idx} == (len_q - 1'b1));
  // The read port always looks ahead at the entry that the next edge loads.
  assign rd_addr    = (state == EXEC && !last_step) ? step_idx + 1'b1 : '0;
  assign mem_we     = prog_we && (state != EXEC);
  assign rd_task    = rd_entry[DWELL_W +: TASK_W];
  assign rd_dwell   = rd_entry[DWELL_W-1:0];
  assign step_valid = (state == EXEC) && (cnt == '0) && !abort;
`ifdef TASK_SEQ_LOOP_EN
  assign wrap       = step_valid && last_step && loop_mode;
`endif

  task_seq_mem #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata ({prog_task, prog_dwell}),
    .raddr (rd_addr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_idx    <= '0;
      task_select <= IDLE_TASK;
      cnt         <= '0;
      len_q       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          task_select <= IDLE_TASK;
          state       <= IDLE;
          if (start && !abort) begin
            len_q <= len_capped;
            if (len_capped == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= EXEC;
              busy        <= 1'b1;
              step_idx    <= '0;
              task_select <= rd_task;
              cnt         <= rd_dwell;
            end
          end
        end
        EXEC: begin
          if (abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            task_select <= IDLE_TASK;
            step_idx    <= '0;
            cnt         <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (last_step) begin
`ifdef TASK_SEQ_LOOP_EN
            if (loop_mode) begin
              step_idx    <= '0;
              task_select <= rd_task;
              cnt         <= rd_dwell;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              task_select <= IDLE_TASK;
              step_idx    <= '0;
            end
`else
            state       <= DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            task_select <= IDLE_TASK;
            step_idx    <= '0;
`endif
          end else begin
            step_idx    <= step_idx + 1'b1;
            task_select <= rd_task;
            cnt         <= rd_dwell;
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          task_select <= IDLE_TASK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_task_sequencer.sv
// Self-checking bench for task_sequencer: directed scenarios plus random
// stimulus, compared every cycle against a trace-based reference model.
module tb_task_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = '0;
  logic [3:0] prog_task = '0;
  logic [2:0] prog_dwell = '0;
  logic [3:0] prog_len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, step_valid;
  logic [3:0] task_select;
  logic [2:0] step_idx;
`ifdef TASK_SEQ_LOOP_EN
  logic       wrap;
`endif

  task_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_task   (prog_task),
    .prog_dwell  (prog_dwell),
    .prog_len    (prog_len),
    .start       (start),
    .abort       (abort),
`ifdef TASK_SEQ_LOOP_EN
    .loop_mode   (1'b0),
    .wrap        (wrap),
`endif
    .busy        (busy),
    .done        (done),
    .task_select (task_select),
    .step_idx    (step_idx),
    .step_valid  (step_valid)
  );

  always #5 clk = ~clk;

  // One expected output vector per clock cycle of a run.
  typedef struct {
    bit       busy;
    bit       done;
    bit [3:0] tsel;
    bit [2:0] idx;
    bit       valid;
  } exp_t;

  exp_t     exp_q[$];
  bit [3:0] shadow_task [8];
  bit [2:0] shadow_dwell [8];
  int       vectors = 0;
  int       miscompares = 0;

  bit [3:0] s_task;
  bit       s_valid, s_done, s_busy;

  task automatic compare(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      shadow_task[i] = '0;
      shadow_dwell[i] = '0;
    end
  endtask

  // Expand a whole run into its cycle-by-cycle trace when start is accepted.
  task automatic build_trace(input int len);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      for (int c = 0; c <= int'(shadow_dwell[k]); c++) begin
        e.busy = 1; e.done = 0; e.tsel = shadow_task[k];
        e.idx = 3'(k); e.valid = (c == int'(shadow_dwell[k]));
        exp_q.push_back(e);
      end
    end
    e.busy = 0; e.done = 1; e.tsel = 0; e.idx = 0; e.valid = 0;
    exp_q.push_back(e);
  endtask

  function automatic exp_t current();
    exp_t e;
    if (exp_q.size() > 0) return exp_q[0];
    e.busy = 0; e.done = 0; e.tsel = 0; e.idx = 0; e.valid = 0;
    return e;
  endfunction

  task automatic checkOutput(input exp_t cur);
    s_task = task_select; s_valid = step_valid; s_done = done; s_busy = busy;
    compare("busy", int'(busy), int'(cur.busy));
    compare("done", int'(done), int'(cur.done));
    compare("task_select", int'(task_select), int'(cur.tsel));
    compare("step_valid", int'(step_valid), int'(cur.valid && !abort));
    if (cur.busy) compare("step_idx", int'(step_idx), int'(cur.idx));
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input bit we,
                               input bit [2:0] addr, input bit [3:0] tk,
                               input bit [2:0] dw, input bit [3:0] ln);
    exp_t cur;
    int len;
    @(negedge clk);
    start = st; abort = ab; prog_we = we; prog_addr = addr;
    prog_task = tk; prog_dwell = dw; prog_len = ln;
    #1;
    cur = current();
    checkOutput(cur);
    if (cur.busy && ab) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (!cur.busy && st && !ab) begin
        len = (ln > 8) ? 8 : int'(ln);
        build_trace(len);
      end
    end
    if (we && !cur.busy) begin
      shadow_task[addr] = tk;
      shadow_dwell[addr] = dw;
    end
  endtask

  task automatic idle_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write_entry(input bit [2:0] a, input bit [3:0] t, input bit [2:0] d);
    applyStimulus(0, 0, 1, a, t, d, 0);
  endtask

  bit [3:0] lit_task [6] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd5, 4'd5};
  bit       lit_valid [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  int       steps_seen;
  int       guard;

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    idle_cycle();
    compare("reset_busy", int'(s_busy), 0);
    compare("reset_task", int'(s_task), 0);

    // Three-entry program: tasks 1;2,2,2;5,5 then done.
    write_entry(0, task_seq_pkg::TASK_ADD, 0);
    write_entry(1, task_seq_pkg::TASK_SHIFT_ALU, 2);
    write_entry(2, task_seq_pkg::TASK_ROTATE, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 3);
    for (int c = 0; c < 7; c++) begin
      idle_cycle();
      if (c < 6) compare("seq_task_lit", int'(s_task), int'(lit_task[c]));
      compare("seq_valid_lit", int'(s_valid), int'(lit_valid[c]));
    end
    compare("seq_done_lit", int'(s_done), 1);
    idle_cycle();
    compare("seq_after_done", int'(s_done), 0);

    // Zero-length program.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idle_cycle();
    compare("len0_done", int'(s_done), 1);
    compare("len0_busy", int'(s_busy), 0);
    idle_cycle();

    // Abort on the 4th EXEC cycle, then a normal rerun.
    write_entry(0, task_seq_pkg::TASK_HOLD_A, 7);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    repeat (3) idle_cycle();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    compare("abort_valid", int'(s_valid), 0);
    idle_cycle();
    compare("abort_idle_task", int'(s_task), 0);
    compare("abort_no_done", int'(s_done), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    repeat (9) idle_cycle();
    compare("rerun_done", int'(s_done), 1);

    // Start and prog_we while busy are both ignored.
    write_entry(0, task_seq_pkg::TASK_HOLD_B, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 4'd9, 0, 4'd5);
    idle_cycle();
    idle_cycle();
    compare("busy_start_done", int'(s_done), 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    idle_cycle();
    compare("readback_task", int'(s_task), 4);

    repeat (3) idle_cycle();

    // Length above DEPTH is clamped to 8 steps.
    for (int k = 0; k < 8; k++) write_entry(3'(k), 4'(k + 1), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 4'd12);
    steps_seen = 0;
    guard = 0;
    do begin
      idle_cycle();
      if (s_valid) steps_seen++;
      guard++;
    end while (!s_done && guard < 40);
    compare("clamp_steps", steps_seen, 8);

    // Asynchronous reset in the middle of a step.
    write_entry(0, task_seq_pkg::TASK_SHIFT_B, 5);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    idle_cycle();
    #2 reset = 1'b1;
    #1;
    compare("async_busy", int'(busy), 0);
    compare("async_task", int'(task_select), 0);
    compare("async_valid", int'(step_valid), 0);
    compare("async_idx", int'(step_idx), 0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    idle_cycle();
    compare("cleared_task", int'(s_task), 0);
    compare("cleared_valid", int'(s_valid), 1);
    idle_cycle();

    // Randomised traffic against the trace model.
    for (int n = 0; n < 2500; n++) begin
      bit st, ab, we;
      st = ($urandom_range(7) == 0);
      ab = ($urandom_range(29) == 0);
      we = ($urandom_range(3) == 0);
      if (st) we = 0;
      applyStimulus(st, ab, we, 3'($urandom_range(7)), 4'($urandom_range(15)),
                    3'($urandom_range(7)), 4'($urandom_range(15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
